// File: rtl/flappy_pkg.sv
// Shared game constants and state encoding for the renderer, bird block and game controller.
// No logic; constants only.
package flappy_pkg;

    localparam logic [9:0] H_VISIBLE   = 10'd640;
    localparam logic [9:0] V_VISIBLE   = 10'd480;
    localparam logic [9:0] BIRD_X      = 10'd120;
    localparam logic [9:0] SCORE_ROW   = 10'd0;
    localparam int         DEAD_FRAMES = 60;
    localparam int         SCORE_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PLAYING = 2'b01,
        ST_DEAD    = 2'b10
    } state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous button, followed by a registered rising-edge pulse.
// Latency: evt pulses for one cycle on the third clock edge after btn rises.
// Backpressure: none; a held button yields a single pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic evt
);

    logic sync1, sync2, sync3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            evt   <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            sync3 <= sync2;
            evt   <= sync2 & ~sync3;
        end
    end

endmodule

// File: rtl/flappy_game_ctrl.sv
// IDLE/PLAYING/DEAD controller: per-frame collision detect, pipe score, renderer enable/restart.
// Latency: outputs registered; state changes one cycle after the deciding event. FLAPPY_HIGH_SCORE_EN adds high_score.
// Backpressure: none; consumes one pixel per clock in lock-step with the scan counters.
module flappy_game_ctrl
    import flappy_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         hCount,
    input  logic [9:0]         vCount,
    input  logic               pipe_pixel,
    input  logic               bird_pixel,
    input  logic               flap_btn,
    output logic               pipe_enable,
    output logic               pipe_rst,
    output logic [1:0]         game_state,
    output logic               collision,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score
);

    localparam int             DCW      = $clog2(DEAD_FRAMES + 1);
    localparam logic [DCW-1:0] DEAD_MAX = DCW'(DEAD_FRAMES);

    state_t         state;
    logic [DCW-1:0] dead_cnt;
    logic           flap_evt;
    logic           hit_flag;
    logic           col_prev;
    logic           frame_start, frame_end, visible, hit_set;
    logic           sample, score_edge, to_dead, restart;

    btn_sync_edge u_flap (
        .clk   (clk),
        .reset (reset),
        .btn   (flap_btn),
        .evt   (flap_evt)
    );

    assign frame_start = (hCount == 10'd0) && (vCount == 10'd0);
    assign frame_end   = (hCount == 10'd0) && (vCount == V_VISIBLE);
    assign visible     = (hCount < H_VISIBLE) && (vCount < V_VISIBLE);
    assign hit_set     = (visible && pipe_pixel && bird_pixel) ||
                         (bird_pixel && (vCount == V_VISIBLE - 10'd1));

    // col_prev holds last frame's sample; the live pipe_pixel is this frame's sample.
    assign sample      = (hCount == BIRD_X) && (vCount == SCORE_ROW);
    assign score_edge  = sample && col_prev && !pipe_pixel;

    assign to_dead     = (state == ST_PLAYING) && frame_end && hit_flag;
    assign restart     = (state == ST_DEAD) && flap_evt && (dead_cnt == DEAD_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_flag <= 1'b0;
        end else if (hit_set) begin
            hit_flag <= 1'b1;
        end else if (frame_start) begin
            hit_flag <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_prev <= 1'b0;
        end else if (restart) begin
            col_prev <= 1'b0;
        end else if (sample) begin
            col_prev <= pipe_pixel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            pipe_enable <= 1'b0;
            pipe_rst    <= 1'b0;
            collision   <= 1'b0;
            score       <= '0;
            dead_cnt    <= '0;
        end else begin
            pipe_rst <= 1'b0;
            case (state)
                ST_IDLE: begin
                    score <= '0;
                    if (flap_evt) begin
                        state       <= ST_PLAYING;
                        pipe_enable <= 1'b1;
                    end
                end
                ST_PLAYING: begin
                    if (score_edge && (score != '1)) begin
                        score <= score + SCORE_W'(1);
                    end
                    if (to_dead) begin
                        state       <= ST_DEAD;
                        pipe_enable <= 1'b0;
                        collision   <= 1'b1;
                        dead_cnt    <= '0;
                    end
                end
                ST_DEAD: begin
                    if (frame_end && (dead_cnt != DEAD_MAX)) begin
                        dead_cnt <= dead_cnt + DCW'(1);
                    end
                    if (restart) begin
                        state     <= ST_IDLE;
                        collision <= 1'b0;
                        pipe_rst  <= 1'b1;
                        score     <= '0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    pipe_enable <= 1'b0;
                    collision   <= 1'b0;
                end
            endcase
        end
    end

    assign game_state = state;

`ifdef FLAPPY_HIGH_SCORE_EN
    // Best score survives restarts; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            high_score <= '0;
        end else if (to_dead && (score > high_score)) begin
            high_score <= score;
        end
    end
`else
    assign high_score = '0;
`endif

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed bench for flappy_game_ctrl: rule-level game model checked every cycle plus literal expectations.
module tb_flappy_game_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] hCount = 10'd700;
    logic [9:0] vCount = 10'd500;
    logic       pipe_pixel = 1'b0;
    logic       bird_pixel = 1'b0;
    logic       flap_btn = 1'b0;
    logic       pipe_enable, pipe_rst, collision;
    logic [1:0] game_state;
    logic [7:0] score, high_score;

    int tests = 0;
    int fails = 0;

    flappy_game_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .hCount      (hCount),
        .vCount      (vCount),
        .pipe_pixel  (pipe_pixel),
        .bird_pixel  (bird_pixel),
        .flap_btn    (flap_btn),
        .pipe_enable (pipe_enable),
        .pipe_rst    (pipe_rst),
        .game_state  (game_state),
        .collision   (collision),
        .score       (score),
        .high_score  (high_score)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural game model ----------------
    int m_state, m_score, m_hi, m_dead;
    bit m_hit, m_last, m_rst;
    bit btn_hist [4];
    bit ev, fs, fe, vis, hs, smp, cleared, restart;
    int h_i, v_i;

    always @(posedge clk) begin
        if (reset) begin
            m_state = 0; m_score = 0; m_hi = 0; m_dead = 0;
            m_hit = 0; m_last = 0; m_rst = 0;
            for (int i = 0; i < 4; i++) btn_hist[i] = 0;
        end else begin
            h_i = int'(hCount);
            v_i = int'(vCount);
            // a button press becomes an event seen by the game three edges after it is first sampled
            ev  = btn_hist[2] && !btn_hist[3];
            fs  = (h_i == 0) && (v_i == 0);
            fe  = (h_i == 0) && (v_i == 480);
            vis = (h_i < 640) && (v_i < 480);
            hs  = (vis && pipe_pixel && bird_pixel) || (bird_pixel && v_i == 479);
            smp = (h_i == 120) && (v_i == 0);
            cleared = smp && m_last && !pipe_pixel;
            restart = 0;
            m_rst = 0;
            if (m_state == 0) begin
                m_score = 0;
                if (ev) m_state = 1;
            end else if (m_state == 1) begin
                if (cleared && m_score < 255) m_score++;
                if (fe && m_hit) begin
`ifdef FLAPPY_HIGH_SCORE_EN
                    if (m_score > m_hi) m_hi = m_score;
`endif
                    m_state = 2;
                    m_dead = 0;
                end
            end else begin
                if (ev && m_dead == 60) begin
                    m_state = 0; m_score = 0; m_rst = 1; restart = 1;
                end
                if (fe && m_dead < 60) m_dead++;
            end
            if (hs) m_hit = 1;
            else if (fs) m_hit = 0;
            if (restart) m_last = 0;
            else if (smp) m_last = pipe_pixel;
            for (int i = 3; i > 0; i--) btn_hist[i] = btn_hist[i-1];
            btn_hist[0] = flap_btn;
        end
    end

    logic [20:0] got_vec, exp_vec;
    always @(posedge clk) begin
        #1;
        got_vec = {game_state, pipe_enable, pipe_rst, collision, score, high_score};
        exp_vec = {2'(m_state), m_state == 1, m_rst, m_state == 2, 8'(m_score), 8'(m_hi)};
        tests++;
        if (got_vec !== exp_vec) begin
            fails++;
            $display("FAIL cycle_model t=%0t: got st=%0d en=%0d rst=%0d col=%0d sc=%0d hi=%0d, expected st=%0d en=%0d rst=%0d col=%0d sc=%0d hi=%0d",
                     $time, got_vec[20:19], got_vec[18], got_vec[17], got_vec[16], got_vec[15:8], got_vec[7:0],
                     exp_vec[20:19], exp_vec[18], exp_vec[17], exp_vec[16], exp_vec[15:8], exp_vec[7:0]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic drive(input int hh, input int vv, input bit p, input bit b);
        @(negedge clk);
        hCount = 10'(hh);
        vCount = 10'(vv);
        pipe_pixel = p;
        bird_pixel = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(700, 500, 1'b0, 1'b0);
    endtask

    task automatic frame(input bit smp_pipe, input int hh, input int hv, input bit hp, input bit hb);
        drive(0, 0, 1'b0, 1'b0);
        drive(120, 0, smp_pipe, 1'b0);
        drive(hh, hv, hp, hb);
        drive(0, 480, 1'b0, 1'b0);
        drive(700, 500, 1'b0, 1'b0);
    endtask

    task automatic plain_frames(input bit smp_pipe, input int n);
        for (int i = 0; i < n; i++) frame(smp_pipe, 300, 200, 1'b0, 1'b0);
    endtask

    task automatic clears(input int n);
        for (int i = 0; i < n; i++) begin
            plain_frames(1'b1, 1);
            plain_frames(1'b0, 1);
        end
    endtask

    task automatic flap();
        flap_btn = 1'b1;
        idle(6);
        flap_btn = 1'b0;
        idle(4);
    endtask

    int lat;
    int rst_pulses;
    int exp_hi;

    initial begin
        idle(3);
        reset = 1'b0;
        idle(2);
        check("reset_state", game_state, 0);
        check("reset_outputs", {pipe_enable, pipe_rst, collision, score, high_score}, 0);

        // flap latency, measured in rising edges after the button goes high
        lat = 0;
        flap_btn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (game_state == 2'b01 && lat == 0) lat = k;
        end
        check("flap_latency", lat, 4);
        check("playing_enable", pipe_enable, 1);
        flap_btn = 1'b0;
        idle(4);

        // game 1: first trailing edge after five covered frames
        plain_frames(1'b1, 5);
        check("score_before_edge", score, 0);
        plain_frames(1'b0, 1);
        check("score_first_edge", score, 1);
        plain_frames(1'b0, 3);
        check("score_static_zero", score, 1);
        clears(2);
        check("score_game1", score, 3);
        frame(1'b0, 640, 200, 1'b1, 1'b1);
        check("blanking_overlap_ignored", game_state, 1);
        frame(1'b0, 300, 200, 1'b1, 1'b1);
        check("dead_after_hit", game_state, 2);
        check("dead_collision", collision, 1);
        check("dead_enable_off", pipe_enable, 0);

        // dead time: early flap discarded, late flap restarts with a held button
        plain_frames(1'b0, 30);
        flap();
        check("early_flap_ignored", game_state, 2);
        clears(1);
        check("score_frozen_dead", score, 3);
        plain_frames(1'b0, 32);
        flap_btn = 1'b1;
        rst_pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            drive(700, 500, 1'b0, 1'b0);
            if (pipe_rst === 1'b1) rst_pulses++;
        end
        flap_btn = 1'b0;
        idle(4);
        check("restart_rst_pulses", rst_pulses, 1);
        check("held_button_single_event", game_state, 0);
        check("restart_score", score, 0);

        // game 2: two clears, floor death
        flap();
        check("game2_playing", game_state, 1);
        clears(2);
        frame(1'b0, 50, 479, 1'b0, 1'b1);
        check("floor_death", game_state, 2);
        check("score_game2", score, 2);
`ifdef FLAPPY_HIGH_SCORE_EN
        exp_hi = 3;
`else
        exp_hi = 0;
`endif
        check("high_score_after_2", high_score, 32'(exp_hi));

        // game 3: saturation, then death on the last visible pixel
        plain_frames(1'b0, 61);
        flap();
        flap();
        check("game3_playing", game_state, 1);
        clears(255);
        check("score_at_max", score, 255);
        clears(1);
        check("score_saturated", score, 255);
        frame(1'b0, 639, 479, 1'b1, 1'b1);
        check("last_pixel_death", game_state, 2);

        // mid-game asynchronous reset
        plain_frames(1'b0, 61);
        flap();
        flap();
        check("game4_playing", game_state, 1);
        drive(400, 100, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_state", game_state, 0);
        check("async_reset_outputs", {pipe_enable, pipe_rst, collision, score, high_score}, 0);
        idle(3);
        reset = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
